// File: rtl/ibus_if_if.sv
// rtl/ibus_if_if.sv - Wishbone-classic read-only instruction bus bundle
interface ibus_if_if;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/ibus_if.sv
// rtl/ibus_if.sv - PC-stage fetch to single Wishbone read, with stall, flush and ack timeout
module ibus_if #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  ibus_if_if.master   wb
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  localparam bit         TMO_EN   = (ACK_TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [31:0] adr_q, adr_nx;
  logic        cyc_q, cyc_nx;
  logic [31:0] rd_buf, rd_buf_nx;
  logic [7:0]  tmo_cnt, tmo_nx;
  logic        err_nx;
  logic        tmo_fire;
  logic        stall_any;

  assign stall_any = |stall;
  // Raw timeout condition; a simultaneous flush still wins in the BUSY branch below.
  assign tmo_fire  = (state == BUSY) && TMO_EN && !wb.wb_ack_i && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nx   = state;
    adr_nx     = adr_q;
    cyc_nx     = cyc_q;
    rd_buf_nx  = rd_buf;
    tmo_nx     = tmo_cnt;
    err_nx     = 1'b0;
    stallreq_o = 1'b0;
    cpu_data_o = 32'h0;
    case (state)
      IDLE: begin
        if (cpu_ce_i && !flush) begin
          stallreq_o = rst;
          adr_nx     = cpu_addr_i;
          cyc_nx     = 1'b1;
          tmo_nx     = 8'd0;
          state_nx   = BUSY;
        end
      end
      BUSY: begin
        stallreq_o = !(wb.wb_ack_i || tmo_fire);
        if (flush) begin
          cyc_nx   = 1'b0;
          state_nx = IDLE;
        end else if (wb.wb_ack_i) begin
          cyc_nx     = 1'b0;
          rd_buf_nx  = wb.wb_dat_i;
          cpu_data_o = wb.wb_dat_i;
          state_nx   = stall_any ? HOLD : IDLE;
        end else if (tmo_fire) begin
          cyc_nx     = 1'b0;
          rd_buf_nx  = NOP_WORD;
          cpu_data_o = NOP_WORD;
          err_nx     = 1'b1;
          state_nx   = stall_any ? HOLD : IDLE;
        end else if (tmo_cnt != 8'hFF) begin
          tmo_nx = tmo_cnt + 8'd1;
        end
      end
      HOLD: begin
        cpu_data_o = rd_buf;
        if (flush || !stall_any) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      adr_q     <= 32'h0;
      cyc_q     <= 1'b0;
      rd_buf    <= 32'h0;
      tmo_cnt   <= 8'd0;
      bus_err_o <= 1'b0;
    end else begin
      state     <= state_nx;
      adr_q     <= adr_nx;
      cyc_q     <= cyc_nx;
      rd_buf    <= rd_buf_nx;
      tmo_cnt   <= tmo_nx;
      bus_err_o <= err_nx;
    end
  end

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_sel_o = 4'b1111;

endmodule

// File: tb/tb_ibus_if.sv
// tb/tb_ibus_if.sv - directed bench for ibus_if with a fetch-transaction reference model
module tb_ibus_if;

  localparam int          TMO = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] cpu_data;
  logic        stallreq;
  logic        bus_err;

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  ibus_if_if bus ();

  ibus_if #(.ACK_TIMEOUT(TMO), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .cpu_ce_i   (ce),
    .cpu_addr_i (addr),
    .cpu_data_o (cpu_data),
    .stallreq_o (stallreq),
    .bus_err_o  (bus_err),
    .wb         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: one outstanding fetch (m_busy) or one held word (m_hold), never both.
  bit          m_busy = 1'b0;
  bit          m_hold = 1'b0;
  bit          m_err  = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_adr  = 32'h0;
  logic [31:0] m_buf  = 32'h0;

  function automatic bit m_tmo();
    return m_busy && (TMO != 0) && !bus.wb_ack_i && (m_wait == TMO - 1);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_hold <= 1'b0; m_err <= 1'b0;
      m_wait <= 0;    m_adr  <= 32'h0; m_buf <= 32'h0;
    end else begin
      m_err <= 1'b0;
      if (m_busy) begin
        if (flush) m_busy <= 1'b0;
        else if (bus.wb_ack_i || m_tmo()) begin
          m_busy <= 1'b0;
          m_buf  <= bus.wb_ack_i ? bus.wb_dat_i : NOP;
          m_err  <= !bus.wb_ack_i;
          m_hold <= (stall != 6'd0);
        end else m_wait <= (m_wait < 255) ? m_wait + 1 : 255;
      end else if (m_hold) begin
        if (flush || stall == 6'd0) m_hold <= 1'b0;
      end else if (ce && !flush) begin
        m_busy <= 1'b1;
        m_adr  <= addr;
        m_wait <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      logic        e_sr;
      logic [31:0] e_data;
      if (!rst)        e_sr = 1'b0;
      else if (m_busy) e_sr = !(bus.wb_ack_i || m_tmo());
      else if (m_hold) e_sr = 1'b0;
      else             e_sr = ce && !flush;
      if (m_busy && !flush && bus.wb_ack_i) e_data = bus.wb_dat_i;
      else if (m_busy && !flush && m_tmo())  e_data = NOP;
      else if (m_hold)                       e_data = m_buf;
      else                                   e_data = 32'h0;
      chk("m_stallreq", stallreq, e_sr);
      chk("m_cpu_data", cpu_data, e_data);
      chk("m_wb_adr",   bus.wb_adr_o, m_adr);
      chk("m_wb_cyc",   bus.wb_cyc_o, m_busy);
      chk("m_wb_stb",   bus.wb_stb_o, m_busy);
      chk("m_bus_err",  bus_err, m_err);
      chk("m_wb_we",    bus.wb_we_o, 1'b0);
      chk("m_wb_sel",   bus.wb_sel_o, 4'b1111);
    end
  end

  initial begin
    int n;
    rst = 1'b0; stall = 6'd0; flush = 1'b0; ce = 1'b0; addr = 32'h0;
    bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0;
    run = 1'b1;
    @(posedge clk); #3;
    chk("rst_stallreq", stallreq, 1'b0);
    chk("rst_data", cpu_data, 32'h0);
    chk("rst_cyc", bus.wb_cyc_o, 1'b0);
    chk("rst_adr", bus.wb_adr_o, 32'h0);
    chk("rst_err", bus_err, 1'b0);
    step();
    rst = 1'b1;
    step();

    // zero-wait fetch
    ce = 1'b1; addr = 32'h0000_0100;
    #2 chk("zw_sr_idle", stallreq, 1'b1);
    step();
    ce = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h3C01_0001;
    #2 chk("zw_data", cpu_data, 32'h3C01_0001);
    chk("zw_adr", bus.wb_adr_o, 32'h0000_0100);
    chk("zw_cyc", bus.wb_cyc_o, 1'b1);
    chk("zw_sr_ack", stallreq, 1'b0);
    step();
    bus.wb_ack_i = 1'b0;
    #2 chk("zw_cyc_after", bus.wb_cyc_o, 1'b0);
    step();

    // three wait states; PC moves while the read is outstanding
    ce = 1'b1; addr = 32'h0000_0104; n = 0;
    #2 n += int'(stallreq);
    step();
    ce = 1'b0; addr = 32'hFFFF_FFF0;
    repeat (3) begin
      #2 n += int'(stallreq);
      chk("ws_data_wait", cpu_data, 32'h0);
      step();
    end
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h1234_5678;
    #2 n += int'(stallreq);
    chk("ws_data", cpu_data, 32'h1234_5678);
    chk("ws_adr", bus.wb_adr_o, 32'h0000_0104);
    step();
    bus.wb_ack_i = 1'b0;
    chk("ws_sr_cycles", n, 4);
    #2 chk("ws_data_after", cpu_data, 32'h0);
    step();

    // stall held past ack -> HOLD; a fetch request in HOLD is ignored
    ce = 1'b1; addr = 32'h0000_0108;
    step();
    ce = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hAABB_CCDD; stall = 6'b000011;
    #2 chk("st_data_ack", cpu_data, 32'hAABB_CCDD);
    step();
    bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0; ce = 1'b1; addr = 32'h0000_0999;
    repeat (2) begin
      #2 chk("st_hold_data", cpu_data, 32'hAABB_CCDD);
      chk("st_hold_sr", stallreq, 1'b0);
      chk("st_hold_cyc", bus.wb_cyc_o, 1'b0);
      step();
    end
    ce = 1'b0; stall = 6'd0;
    #2 chk("st_release_data", cpu_data, 32'hAABB_CCDD);
    step();
    #2 chk("st_idle_data", cpu_data, 32'h0);
    step();

    // flush in the second BUSY cycle with a same-cycle ack
    ce = 1'b1; addr = 32'h0000_010C;
    step();
    ce = 1'b0; addr = 32'h0000_0200;
    #2 chk("fl_cyc_busy", bus.wb_cyc_o, 1'b1);
    step();
    flush = 1'b1; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEAD_BEEF; stall = 6'b000010;
    #2 chk("fl_data", cpu_data, 32'h0);
    step();
    flush = 1'b0; bus.wb_ack_i = 1'b0;
    #2 chk("fl_cyc_after", bus.wb_cyc_o, 1'b0);
    chk("fl_no_hold", cpu_data, 32'h0);
    step();
    stall = 6'd0; ce = 1'b1;
    step();
    ce = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h1111_2222;
    #2 chk("fl_new_adr", bus.wb_adr_o, 32'h0000_0200);
    chk("fl_new_data", cpu_data, 32'h1111_2222);
    step();
    bus.wb_ack_i = 1'b0;
    step();

    // ack timeout after four BUSY cycles
    ce = 1'b1; addr = 32'h0000_0300;
    step();
    ce = 1'b0;
    repeat (3) begin
      #2 chk("to_sr_wait", stallreq, 1'b1);
      chk("to_err_wait", bus_err, 1'b0);
      step();
    end
    #2 chk("to_nop", cpu_data, NOP);
    chk("to_sr_abort", stallreq, 1'b0);
    step();
    #2 chk("to_cyc_after", bus.wb_cyc_o, 1'b0);
    chk("to_err_pulse", bus_err, 1'b1);
    step();
    #2 chk("to_err_clear", bus_err, 1'b0);
    step();

    // asynchronous reset in the middle of BUSY
    ce = 1'b1; addr = 32'h0000_0400;
    step();
    ce = 1'b0;
    #2 chk("ar_cyc_busy", bus.wb_cyc_o, 1'b1);
    rst = 1'b0;
    #1 chk("ar_cyc", bus.wb_cyc_o, 1'b0);
    chk("ar_sr", stallreq, 1'b0);
    chk("ar_adr", bus.wb_adr_o, 32'h0);
    ce = 1'b1; addr = 32'h0000_0500;
    #1 chk("ar_sr_ce", stallreq, 1'b0);
    step();
    rst = 1'b1;
    #2 chk("ar_sr_release", stallreq, 1'b1);
    step();
    ce = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h55AA_55AA;
    #2 chk("ar_new_adr", bus.wb_adr_o, 32'h0000_0500);
    chk("ar_new_data", cpu_data, 32'h55AA_55AA);
    step();
    bus.wb_ack_i = 1'b0;
    step();
    step();

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibus_if.md
# ibus_if

Instruction-bus interface between the PC stage and the external instruction memory bus (Wishbone-classic, read-only). It converts each fetch address from the PC stage into a single bus read cycle. While the read is outstanding, it asserts a stall request to the pipeline controller. It presents the fetched word to the IF/ID register, discards in-flight reads on flush, and aborts reads that exceed a timeout.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 255: maximum cycles in BUSY without `wb_ack_i`; 0 disables the timeout.
- `NOP_WORD`, default 32'h0000_0000: instruction returned on timeout abort.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall`  in  6  pipeline stall vector; `stall[1]` = IF/ID stage held.
- `flush`  in  1  exception flush; kills any outstanding fetch.
- `cpu_ce_i`  in  1  fetch enable from the PC stage.
- `cpu_addr_i`  in  32  fetch address (PC).
- `cpu_data_o`  out  32  instruction word to IF/ID (combinational).
- `stallreq_o`  out  1  fetch stall request to the pipeline controller (combinational).
- `bus_err_o`  out  1  one-cycle pulse on timeout abort.
- `wb_adr_o`  out  32  bus address (registered).
- `wb_cyc_o`, `wb_stb_o`  out  1  bus cycle and strobe (registered, always equal).
- `wb_we_o`  out  1  tied 0.
- `wb_sel_o`  out  4  tied 4'b1111.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`  in  1  read acknowledge.

## Operation
- States: IDLE, BUSY, HOLD.
- Registers: state, `wb_adr_o`, `wb_cyc_o`/`wb_stb_o`, `rd_buf[31:0]`, `tmo_cnt[7:0]`, `bus_err_o`.

IDLE
- When `cpu_ce_i`=1 and `flush`=0: on the next edge, `wb_adr_o` <= `cpu_addr_i`, cyc/stb <= 1, `tmo_cnt` <= 0, state <= BUSY.
- Otherwise remain in IDLE.

BUSY, `flush`=1 (highest priority)
- cyc/stb <= 0, state <= IDLE.
- Data is discarded, even if `wb_ack_i`=1 in the same cycle.

BUSY, `wb_ack_i`=1 and `flush`=0
- cyc/stb <= 0, `rd_buf` <= `wb_dat_i`.
- state <= HOLD if `stall`≠0, else IDLE.

BUSY, timeout (`ACK_TIMEOUT`≠0 and `tmo_cnt`==`ACK_TIMEOUT`-1 with no ack)
- cyc/stb <= 0, `rd_buf` <= `NOP_WORD`, `bus_err_o` <= 1 for one cycle.
- state <= HOLD if `stall`≠0, else IDLE.

BUSY, otherwise
- `tmo_cnt` increments, saturating at 255.

HOLD
- Waits for the pipeline to release.
- state <= IDLE when `stall`==0.
- `flush`=1 forces IDLE.

`stallreq_o` (combinational)
- IDLE: 1 iff `cpu_ce_i`=1 and `flush`=0.
- BUSY: 1 unless `wb_ack_i`=1 or the timeout fires this cycle.
- HOLD: 0.

`cpu_data_o` (combinational)
- BUSY with ack: `wb_dat_i`.
- BUSY with timeout: `NOP_WORD`.
- HOLD: `rd_buf`.
- All other cases: 0.

Other rules
- `cpu_addr_i` is sampled only in IDLE; later PC changes do not affect an outstanding read.
- The block never issues back-to-back cycles without passing through IDLE.
- Minimum one idle bus cycle between reads.

## Timing
- Reset (`rst`=0, asynchronous) forces: state=IDLE, `wb_adr_o`=0, cyc/stb=0, `rd_buf`=0, `tmo_cnt`=0, `bus_err_o`=0.
- Outputs in reset: `stallreq_o`=0, `cpu_data_o`=0.
- Reset asserted mid-BUSY drops cyc/stb immediately, with no wait for ack.
- Latency with zero-wait memory (ack in the first BUSY cycle): request edge T, ack at T+1, data valid on `cpu_data_o` during T+1.
- One fetch costs 2 cycles; each memory wait state adds 1.
- `stallreq_o` is high from the cycle `cpu_ce_i` is seen in IDLE until the ack cycle, inclusive of the IDLE cycle, exclusive of the ack cycle.
- `bus_err_o` is high exactly one cycle, the cycle after the abort edge.

## Test plan
- **Zero-wait fetch:** `cpu_addr_i`=0x0000_0100, memory acks at first BUSY cycle with 0x3C01_0001 -> `wb_adr_o`=0x100, cyc/stb high 1 cycle, `cpu_data_o`=0x3C01_0001 in the ack cycle, `stallreq_o` high exactly 1 cycle.
- **Wait states:** ack delayed 3 cycles -> `stallreq_o` high 4 cycles, `tmo_cnt` reaches 3, data presented in ack cycle only.
- **Stall after ack:** `stall`=6'b000011 held 2 cycles past ack with data 0xAABB_CCDD -> state HOLD, `cpu_data_o`=0xAABB_CCDD and `stallreq_o`=0 throughout, IDLE when `stall` clears.
- **Flush mid-read:** `flush`=1 in the second BUSY cycle, ack arriving the same cycle -> cyc/stb low next edge, `cpu_data_o`=0, no HOLD, next fetch uses the new `cpu_addr_i`.
- **Timeout:** `ACK_TIMEOUT`=4, no ack -> abort after 4 BUSY cycles, `cpu_data_o`=`NOP_WORD` in the abort cycle, `bus_err_o` pulses 1 cycle, cyc/stb low.
- **Async reset mid-BUSY:** `rst` low between edges -> cyc/stb and `stallreq_o` low immediately, all registers at reset values, first fetch after release reads from the then-current `cpu_addr_i`.
